// File: rtl/multi_encoder.sv
// multi_encoder: sequential one-hot to binary encoder for K concatenated lanes.
// One lane is encoded per clock. The packed index string and the per-lane
// error flags are returned over a valid/ready handshake. A lane is flagged
// when it does not hold exactly one set bit; its index is then the lowest
// set bit, or zero for an empty lane.
module multi_encoder #(
  parameter int SIZE = 8,
  parameter int BIT  = $clog2(SIZE),
  parameter int K    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [K*SIZE-1:0]   onehot_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [K*BIT-1:0]    string_o,
  output logic [K-1:0]        err_o,
  output logic                busy_o
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Returns {err, index} for one lane: index of the lowest set bit,
  // err set unless exactly one bit is set.
  function automatic logic [BIT:0] encode_lane(input logic [SIZE-1:0] lane);
    logic [BIT-1:0] idx;
    int unsigned    ones;
    idx  = '0;
    ones = 32'd0;
    // Scanning downward leaves the lowest set bit's position in idx.
    for (int i = SIZE - 1; i >= 0; i--) begin
      idx  = lane[i] ? BIT'(i) : idx;
      ones = ones + 32'(lane[i]);
    end
    return {(ones != 32'd1), idx};
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [K*SIZE-1:0]     vec_q, vec_d;
  logic [K*BIT-1:0]      string_q, string_d;
  logic [K-1:0]          err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic [SIZE-1:0]       lane_s;
  logic [BIT:0]          enc_s;

  // Lane currently addressed by the counter and its encoding.
  always_comb begin
    lane_s = vec_q[int'(cnt_q) * SIZE +: SIZE];
    enc_s  = encode_lane(lane_s);
  end

  // Next-state and datapath update for the IDLE/ENCODE/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    string_d    = string_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          vec_d    = onehot_i;
          string_d = '0;
          err_d    = '0;
          cnt_d    = '0;
          state_d  = ENCODE;
        end else begin
          state_d  = IDLE;
        end
      end
      ENCODE: begin
        string_d[int'(cnt_q) * BIT +: BIT] = enc_s[BIT-1:0];
        err_d[cnt_q]                       = enc_s[BIT];
        if (cnt_q == CNT_LAST) begin
          // Counter parks at K-1 until the next acceptance clears it.
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      string_q    <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      string_q    <= string_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == ENCODE);
  assign out_valid_o = out_valid_q;
  assign string_o    = string_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_multi_encoder.sv
// Self-checking bench for multi_encoder (SIZE=8, BIT=3, K=4) with a
// behavioural lane model and a behavioural multi one-hot decoder.
module tb_multi_encoder;

  localparam int SIZE = 8;
  localparam int BIT  = 3;
  localparam int K    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [K*SIZE-1:0]   onehot;
  logic                out_valid;
  logic                out_ready;
  logic [K*BIT-1:0]    string_v;
  logic [K-1:0]        err;
  logic                busy;

  int total = 0;
  int bad   = 0;

  multi_encoder #(.SIZE(SIZE), .BIT(BIT), .K(K)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .onehot_i    (onehot),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .string_o    (string_v),
    .err_o       (err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: lowest set bit via isolate-lowest-bit arithmetic.
  function automatic void ref_model(input logic [31:0] v, output logic [11:0] s, output logic [3:0] e);
    int lane;
    int lo;
    int idx;
    s = 12'h000;
    e = 4'b0000;
    for (int i = 0; i < K; i++) begin
      lane = int'((v >> (i * SIZE)) & 32'hFF);
      lo   = lane & (-lane);
      idx  = (lane == 0) ? 0 : $clog2(lo);
      e[i] = (lane == 0) || ((lane & (lane - 1)) != 0);
      s[i*BIT +: BIT] = idx[2:0];
    end
  endfunction

  // Behavioural multi one-hot decoder: index string to one-hot lanes.
  function automatic logic [31:0] decode(input logic [11:0] s);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < K; i++) begin
      v = v | (32'h1 << (i * SIZE + int'(s[i*BIT +: BIT])));
    end
    return v;
  endfunction

  // Present v at the next IDLE cycle and hold it for the acceptance edge.
  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    onehot   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    onehot   = $urandom;
  endtask

  // Count edges from acceptance until out_valid, bounded; expect K.
  task automatic wait_result();
    int lat;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      check("busy_encode", {31'd0, busy}, 32'd1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, K);
    check("busy_done", {31'd0, busy}, 32'd0);
  endtask

  // Hand the result to the consumer and confirm the return to IDLE.
  task automatic consume(input logic [11:0] s_exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("ov_cleared", {31'd0, out_valid}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("str_retained", {20'd0, string_v}, {20'd0, s_exp});
  endtask

  task automatic run_txn(input string tag, input logic [31:0] v);
    logic [11:0] s;
    logic [3:0]  e;
    ref_model(v, s, e);
    send(v);
    wait_result();
    check({tag, "_str"}, {20'd0, string_v}, {20'd0, s});
    check({tag, "_err"}, {28'd0, err}, {28'd0, e});
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check({tag, "_hold"}, {20'd0, string_v}, {20'd0, s});
    end
    consume(s);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] sa, sb, idx_s;
    logic [3:0]  ea, eb;
    logic [31:0] va, vb, v;
    int          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    onehot    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_string", {20'd0, string_v}, 32'h000);
    check("rst_err", {28'd0, err}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Directed legal vector with fixed expectations.
    send(32'h04108001);
    wait_result();
    check("legal_str", {20'd0, string_v}, 32'h538);
    check("legal_err", {28'd0, err}, 32'h0);
    consume(12'h538);

    // Directed vector with an empty lane and a two-bit lane.
    send(32'h04120001);
    wait_result();
    check("illegal_str", {20'd0, string_v}, 32'h440);
    check("illegal_err", {28'd0, err}, 32'b0110);
    consume(12'h440);

    // Back-pressure in DONE with in_valid held high, then the next vector.
    va = 32'h80402010;
    vb = 32'h01020408;
    ref_model(va, sa, ea);
    ref_model(vb, sb, eb);
    send(va);
    wait_result();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      onehot = $urandom;
      @(negedge clk);
      check("bp_str", {20'd0, string_v}, {20'd0, sa});
      check("bp_err", {28'd0, err}, {28'd0, ea});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    onehot    = vb;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle", {31'd0, in_ready}, 32'd1);
    check("bp_retained", {20'd0, string_v}, {20'd0, sa});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    onehot   = $urandom;
    wait_result();
    check("bp_next_str", {20'd0, string_v}, {20'd0, sb});
    check("bp_next_err", {28'd0, err}, {28'd0, eb});
    consume(sb);

    // Reset two cycles into ENCODE: outputs clear at once, nothing follows.
    send(32'h10204080);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_str", {20'd0, string_v}, 32'h0);
    check("mid_rst_err", {28'd0, err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_ov", seen, 0);

    // Random lanes mixing empty, legal, multi-bit and arbitrary bytes.
    for (int n = 0; n < 50; n++) begin
      v = 32'h0;
      for (int i = 0; i < K; i++) begin
        case ($urandom_range(0, 3))
          0: v = v;
          1: v = v | (32'h1 << (i * SIZE + $urandom_range(0, 7)));
          2: v = v | ((32'h1 << (i * SIZE + $urandom_range(0, 7))) |
                      (32'h1 << (i * SIZE + $urandom_range(0, 7))));
          default: v = v | ((32'($urandom) & 32'hFF) << (i * SIZE));
        endcase
      end
      run_txn("rand", v);
    end

    // Round trip through the behavioural decoder.
    for (int n = 0; n < 200; n++) begin
      idx_s = 12'($urandom);
      send(decode(idx_s));
      wait_result();
      check("rt_str", {20'd0, string_v}, {20'd0, idx_s});
      check("rt_err", {28'd0, err}, 32'h0);
      consume(idx_s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
